spi_controller: RTL
===================

# spi_controller

- SPI mode-0 initiator for the onboarding design: the controller end of the write-only register link.
- Drives `nCS`, `SCLK` and `COPI` to the SPI peripheral register block.
- Each request becomes one 16-bit frame `{1'b1, addr[6:0], data[7:0]}`, sent MSB first.
- Used by the on-chip configuration sequencer and the test harness to program the output-enable, PWM-enable and duty-cycle registers.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per `SCLK` half-period. Legal range is ≥4, because the receiver synchronises `SCLK` through two flops.
- `GAP_CYCLES`, 8: minimum `clk` cycles with `nCS` high between frames. Legal range is ≥4.

Ports:
- `clk` input 1: single system clock; everything is synchronous to it.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: a write request is presented.
- `req_ready` output 1: a request can be accepted this cycle.
- `req_addr` input 7: register address, placed in frame bits [14:8].
- `req_data` input 8: register data, placed in frame bits [7:0].
- `nCS` output 1: chip select, active low, registered.
- `SCLK` output 1: serial clock, idles low, registered.
- `COPI` output 1: serial data, registered.
- `busy` output 1: a frame is in flight or a request is pending.
- `done` output 1: one-cycle pulse in the cycle `nCS` returns high.

## Operation
Request handling:
- A request is accepted on a rising `clk` edge when `req_valid && req_ready`.
- Accepted requests enter the request store: a single holding register, or a FIFO (see Configuration).

State machine `IDLE → SETUP → SHIFT → HOLD → GAP → IDLE`:
- **IDLE**
  - Outputs: `nCS`=1, `SCLK`=0, `COPI`=0.
  - If the store is non-empty: pop it into the 16-bit shift register, drive `nCS`←0 and `COPI`←frame[15], load `bit_cnt`=0 and `div_cnt`=0, go to SETUP.
- **SETUP**
  - Hold `SCLK` low for `CLK_DIV` cycles.
  - Then `SCLK`←1 (first rising edge) and go to SHIFT.
- **SHIFT**
  - High phase: `SCLK` stays high for `CLK_DIV` cycles, then `SCLK`←0.
  - If `bit_cnt`<15 at that point: shift, drive `COPI`←next bit, increment `bit_cnt`.
  - Low phase: `SCLK` stays low for `CLK_DIV` cycles, then `SCLK`←1.
  - After the 16th high phase ends (`bit_cnt`==15), go to HOLD instead.
  - `COPI` changes only on falling `SCLK` or at frame start, so it is stable for ≥`CLK_DIV` cycles around each rising edge.
- **HOLD**
  - `nCS` stays low and `SCLK` stays low for `CLK_DIV` cycles.
  - Then `nCS`←1, `COPI`←0, `done`←1 for one cycle, go to GAP.
- **GAP**
  - Count `GAP_CYCLES` cycles, then return to IDLE.

Other rules:
- `busy` = (state≠IDLE) || (store non-empty).
- Counters:
  - `div_cnt` is `$clog2(CLK_DIV)` bits and wraps to 0 at `CLK_DIV`-1.
  - `bit_cnt` is 4 bits.
  - The gap counter is `$clog2(GAP_CYCLES+1)` bits.
- Reset mid-frame: all outputs take their reset values immediately (asynchronous), the store is flushed, no `done` is produced, and the partial frame is abandoned. The peripheral discards it on `nCS` rise.

## Timing
- Reset values: `nCS`=1, `SCLK`=0, `COPI`=0, `busy`=0, `done`=0, `req_ready`=1. State is IDLE and the store is empty.
- Request accepted at edge N with the controller idle and the store empty:
  - `nCS` falls at edge N+2 (store write at N, pop/launch at N+1, output flop at N+2).
  - First `SCLK` rise at N+2+`CLK_DIV`.
  - `nCS` rises and `done` pulses at N+2+33·`CLK_DIV`.
- `nCS` low time is exactly 33·`CLK_DIV` cycles.
- Frame spacing: 16 rising `SCLK` edges per frame, and no `SCLK` edge while `nCS` is high.
- Back-to-back frames: the next `nCS` fall is no earlier than `GAP_CYCLES`+1 cycles after `nCS` rises.

## Configuration
- `SPI_CTRL_QUEUE_EN` defined:
  - The store is a 4-entry FIFO and `req_ready` = (count<4).
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- `SPI_CTRL_QUEUE_EN` undefined:
  - The store is a single holding register and `req_ready` = holding register empty.
  - The register frees in the cycle it is popped into the shift register, so one request can wait while a frame shifts.
  - No same-cycle push and pop.

## Test plan
- **Reset:** assert `rst_n`=0.
  - Required: `nCS`=1, `SCLK`=0, `COPI`=0, `busy`=0, `done`=0, `req_ready`=1.
- **Single write** (`CLK_DIV`=4): addr 0x04, data 0xA5.
  - Required: COPI sampled on 16 rising `SCLK` edges equals 0x84A5.
  - Required: `nCS` low for 132 cycles, exactly one `done` pulse, `busy` low after GAP.
- **Back-to-back writes:** (0x00,0xFF) then (0x02,0x0F).
  - Required: two frames 0x80FF and 0x820F, separated by ≥8 cycles of `nCS` high.
  - Without `SPI_CTRL_QUEUE_EN`: a third request is stalled (`req_ready`=0) until the second frame launches.
- **Queue full** (`SPI_CTRL_QUEUE_EN`): 6 consecutive requests.
  - Required: the first pops immediately, the next 4 fill the FIFO, and the 6th sees `req_ready`=0 until the next launch.
  - Required: all 6 frames transmitted in order.
- **Reset mid-frame:** drop `rst_n` after 7 rising `SCLK` edges.
  - Required: `nCS`=1 at once, no `done`, store empty.
  - Required: after release, a new request (0x03,0x55) transmits 0x8355 correctly.
- **Loopback with the SPI peripheral:** write (0x01,0x3C) then (0x04,0x80).
  - Required: `en_reg_out_15_8`=0x3C and `pwm_duty_cycle`=0x80; other registers stay 0x00.

Source files
------------

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//
// SPI mode-0 initiator for the write-only register link. Every accepted
// request becomes one 16-bit frame {1'b1, addr[6:0], data[7:0]}, shifted out
// MSB first. COPI changes only while SCLK falls (or at frame start), so the
// peripheral can sample on the rising edge.
//
// The FSM runs one cycle ahead of the pins. nCS, SCLK, COPI and done are
// plain flops of the FSM's combinational view of the pins, so the pins are
// glitch-free. A request accepted at edge N is launched by the FSM at N+1
// and shows as nCS falling at N+2.
//
// Parameters:
//   CLK_DIV     clk cycles per SCLK half-period (>= 4)
//   GAP_CYCLES  minimum clk cycles with nCS high between frames (>= 4)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  write request presented
//   req_ready  request can be accepted this cycle
//   req_addr   register address -> frame[14:8]
//   req_data   register data    -> frame[7:0]
//   nCS        chip select, active low (registered)
//   SCLK       serial clock, idles low (registered)
//   COPI       serial data (registered)
//   busy       frame in flight or request pending
//   done       one-cycle pulse in the cycle nCS returns high
//
// Build option:
//   SPI_CTRL_QUEUE_EN  defined   -> 4-entry request FIFO
//                      undefined -> single holding register
// ---------------------------------------------------------------------------
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  // -------------------------------------------------------------------------
  // Request store
  // -------------------------------------------------------------------------
  logic [15:0] frame_in;
  logic [15:0] store_head;
  logic        store_empty;
  logic        push;
  logic        pop;
  state_t      state;

  assign frame_in = {1'b1, req_addr, req_data};
  assign push     = req_valid && req_ready;
  // The FSM takes the head of the store only from IDLE.
  assign pop      = (state == S_IDLE) && !store_empty;

`ifdef SPI_CTRL_QUEUE_EN
  logic [15:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  assign store_empty = (count == 3'd0);
  assign req_ready   = (count != 3'd4);
  assign store_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage array has no reset; count alone says which entries are
  // valid, so resetting the data would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= frame_in;
  end
`else
  logic        hold_valid;
  logic [15:0] hold_frame;

  assign store_empty = !hold_valid;
  assign req_ready   = !hold_valid;
  assign store_head  = hold_frame;

  // push needs an empty register and pop needs a full one, so the two never
  // coincide. The register frees on the pop edge, letting one request wait
  // while the current frame shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_frame <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_frame <= frame_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Frame sequencer
  // -------------------------------------------------------------------------
  state_t           state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [3:0]       bit_cnt, bit_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic             sclk_high, sclk_high_d;  // current SCLK half-period is high
  logic [15:0]      shreg, shreg_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sclk_high <= 1'b0;
      shreg     <= '0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_d;
      bit_cnt   <= bit_d;
      gap_cnt   <= gap_d;
      sclk_high <= sclk_high_d;
      shreg     <= shreg_d;
    end
  end

  // NOTE: every variable gets its hold value before the case statement so
  // no path through the logic leaves one unassigned (no latches).
  always_comb begin
    state_d     = state;
    div_d       = div_cnt;
    bit_d       = bit_cnt;
    gap_d       = gap_cnt;
    sclk_high_d = sclk_high;
    shreg_d     = shreg;

    case (state)
      S_IDLE: begin
        if (!store_empty) begin
          shreg_d     = store_head;
          div_d       = '0;
          bit_d       = '0;
          sclk_high_d = 1'b0;
          state_d     = S_SETUP;
        end
      end

      // SCLK held low for one half-period with the MSB already on COPI.
      S_SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_d       = '0;
          sclk_high_d = 1'b1;
          state_d     = S_SHIFT;
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end

      // Alternating half-periods. The next bit is presented as a high phase
      // ends, i.e. together with the falling SCLK edge.
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_d = '0;
          if (sclk_high) begin
            sclk_high_d = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_d = S_HOLD;
            end else begin
              shreg_d = {shreg[14:0], 1'b0};
              bit_d   = bit_cnt + 4'd1;
            end
          end else begin
            sclk_high_d = 1'b1;
          end
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end

      // Keep nCS low one more half-period after the last falling edge.
      S_HOLD: begin
        if (div_cnt == DIV_LAST) begin
          div_d   = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Pin registers
  // -------------------------------------------------------------------------
  logic ncs_d;
  logic sclk_d;
  logic copi_d;
  logic done_d;

  always_comb begin
    ncs_d  = !(state inside {S_SETUP, S_SHIFT, S_HOLD});
    sclk_d = (state == S_SHIFT) && sclk_high;
    copi_d = ncs_d ? 1'b0 : shreg[15];
    // Pulse exactly when nCS is about to go high; a reset forces nCS high
    // directly, so an abandoned frame never reaches this.
    done_d = ncs_d && !nCS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nCS  <= 1'b1;
      SCLK <= 1'b0;
      COPI <= 1'b0;
      done <= 1'b0;
    end else begin
      nCS  <= ncs_d;
      SCLK <= sclk_d;
      COPI <= copi_d;
      done <= done_d;
    end
  end

  assign busy = (state != S_IDLE) || !store_empty;

endmodule
